// File: rtl/accumulator_datapath.sv
// PC, accumulator and run/halt sequencer for the 3-bit accumulator ISA.
// Define OVERFLOW_FLAG_EN to add the sticky signed-overflow output ovf.
module accumulator_datapath #(
   parameter int DATA_W   = 8,
   parameter int OPR_W    = 5,
   parameter int START_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [OPR_W-1:0]  imem_addr,
   input  logic [OPR_W+2:0]  imem_data,
   output logic [2:0]        opcode,
   input  logic              rd_mem,
   input  logic              wr_mem,
   input  logic              ac_src,
   input  logic              ld_ac,
   input  logic              pc_src,
   input  logic              alu_add,
   input  logic              alu_sub,
   output logic [OPR_W-1:0]  dmem_addr,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] acc,
   output logic              running,
   output logic              halted
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic              ovf
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [2:0] OP_JEZ = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam logic [OPR_W-1:0] START_ADDR = OPR_W'(START_PC);

   logic [1:0]        state_q, state_d;
   logic [OPR_W-1:0]  pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [OPR_W-1:0]  operand;
   logic [DATA_W-1:0] sum, diff;

   assign opcode     = imem_data[OPR_W+2:OPR_W];
   assign operand    = imem_data[OPR_W-1:0];
   assign sum        = acc_q + dmem_rdata;
   assign diff       = acc_q - dmem_rdata;

   assign imem_addr  = pc_q;
   assign dmem_addr  = operand;
   assign dmem_wdata = acc_q;
   assign acc        = acc_q;
   assign running    = (state_q == ST_RUN);
   assign halted     = (state_q == ST_HALT);

   // A reset arriving together with a store must not let the store reach memory.
   assign dmem_re    = rd_mem & running & ~rst;
   assign dmem_we    = wr_mem & running & ~rst;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      case (state_q)
         ST_RUN: begin
            if (opcode == OP_HLT) begin
               state_d = ST_HALT;
            end else begin
               if (opcode == OP_LDI) begin
                  acc_d = DATA_W'($signed(operand));
               end else if (ld_ac) begin
                  if (ac_src)       acc_d = dmem_rdata;
                  else if (alu_add) acc_d = sum;
                  else if (alu_sub) acc_d = diff;
               end
               // JEZ tests the accumulator value before this instruction retires.
               if (pc_src)                                   pc_d = operand;
               else if (opcode == OP_JEZ && acc_q == '0)     pc_d = operand;
               else                                          pc_d = pc_q + OPR_W'(1);
            end
         end
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = START_ADDR;
               acc_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= START_ADDR;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic ovf_q, ovf_d;
   logic add_ovf, sub_ovf;

   assign add_ovf = (acc_q[DATA_W-1] == dmem_rdata[DATA_W-1]) && (sum[DATA_W-1]  != acc_q[DATA_W-1]);
   assign sub_ovf = (acc_q[DATA_W-1] != dmem_rdata[DATA_W-1]) && (diff[DATA_W-1] != acc_q[DATA_W-1]);

   always_comb begin
      ovf_d = ovf_q;
      if (state_q != ST_RUN) begin
         if (start) ovf_d = 1'b0;
      end else if (opcode != OP_HLT && opcode != OP_LDI && ld_ac && !ac_src) begin
         if (alu_add)      ovf_d = ovf_q | add_ovf;
         else if (alu_sub) ovf_d = ovf_q | sub_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_accumulator_datapath.sv
// Self-checking bench for accumulator_datapath: directed ISA programs plus random programs
// compared cycle by cycle against an instruction-level reference model.
module tb_accumulator_datapath;

   localparam int DW = 8;
   localparam int OW = 5;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_STA = 3'b011;
   localparam logic [2:0] OP_JMP = 3'b100;
   localparam logic [2:0] OP_JEZ = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [OW-1:0] imem_addr, dmem_addr;
   logic [OW+2:0] imem_data;
   logic [2:0]    opcode;
   logic rd_mem, wr_mem, ac_src, ld_ac, pc_src, alu_add, alu_sub;
   logic dmem_re, dmem_we, running, halted;
   logic [DW-1:0] dmem_wdata, dmem_rdata, acc;
`ifdef OVERFLOW_FLAG_EN
   logic ovf;
`endif

   logic [OW+2:0] imem  [32];
   logic [DW-1:0] dmem  [32];
   logic [DW-1:0] m_mem [32];
   int       m_state, m_pc;
   logic [7:0] m_acc;
   logic     m_ovf;
   int checks = 0;
   int errors = 0;

   accumulator_datapath #(.DATA_W(DW), .OPR_W(OW), .START_PC(0)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data), .opcode(opcode),
      .rd_mem(rd_mem), .wr_mem(wr_mem), .ac_src(ac_src), .ld_ac(ld_ac),
      .pc_src(pc_src), .alu_add(alu_add), .alu_sub(alu_sub),
      .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .acc(acc),
      .running(running), .halted(halted)
`ifdef OVERFLOW_FLAG_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   assign imem_data  = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   // Opcode decoder that sits outside the datapath.
   always_comb begin
      rd_mem = 1'b0; wr_mem = 1'b0; ac_src = 1'b0; ld_ac = 1'b0;
      pc_src = 1'b0; alu_add = 1'b0; alu_sub = 1'b0;
      case (opcode)
         OP_LDA:  begin rd_mem = 1'b1; ac_src = 1'b1; ld_ac = 1'b1; end
         OP_ADD:  begin rd_mem = 1'b1; alu_add = 1'b1; ld_ac = 1'b1; end
         OP_SUB:  begin rd_mem = 1'b1; alu_sub = 1'b1; ld_ac = 1'b1; end
         OP_STA:  wr_mem = 1'b1;
         OP_JMP:  pc_src = 1'b1;
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-level reference: one architectural step per clock.
   task automatic model_step(input logic st, input logic rs);
      logic [2:0] op;
      logic [4:0] opr;
      int nxt, s, v;
      if (rs) begin
         m_state = S_IDLE; m_pc = 0; m_acc = 8'h00; m_ovf = 1'b0;
      end else if (m_state != S_RUN) begin
         if (st) begin
            m_state = S_RUN; m_pc = 0; m_acc = 8'h00; m_ovf = 1'b0;
         end
      end else begin
         op  = imem[m_pc[4:0]][7:5];
         opr = imem[m_pc[4:0]][4:0];
         nxt = (m_pc + 1) % 32;
         case (op)
            OP_LDA: m_acc = m_mem[opr];
            OP_ADD: begin
               s = $signed(m_acc) + $signed(m_mem[opr]);
               if (s > 127 || s < -128) m_ovf = 1'b1;
               m_acc = m_acc + m_mem[opr];
            end
            OP_SUB: begin
               s = $signed(m_acc) - $signed(m_mem[opr]);
               if (s > 127 || s < -128) m_ovf = 1'b1;
               m_acc = m_acc - m_mem[opr];
            end
            OP_STA: m_mem[opr] = m_acc;
            OP_JMP: nxt = int'(opr);
            OP_JEZ: if (m_acc == 8'h00) nxt = int'(opr);
            OP_LDI: begin
               v = int'(opr);
               if (v >= 16) v = v - 32;
               m_acc = v[7:0];
            end
            default: begin
               m_state = S_HALT;
               nxt = m_pc;
            end
         endcase
         m_pc = nxt;
      end
   endtask

   task automatic cycle(input logic st, input logic rs, input bit do_chk);
      logic [2:0] op;
      logic cap_we;
      logic [4:0] cap_addr;
      logic [7:0] cap_data;
      bit run_now;
      @(negedge clk);
      start = st;
      rst   = rs;
      #1;
      op = imem[m_pc[4:0]][7:5];
      run_now = (m_state == S_RUN) && !rs;
      if (do_chk) begin
         chk("pc", 32'(imem_addr), 32'(m_pc));
         chk("acc", 32'(acc), 32'(m_acc));
         chk("running", 32'(running), (m_state == S_RUN) ? 1 : 0);
         chk("halted", 32'(halted), (m_state == S_HALT) ? 1 : 0);
         chk("dmem_we", 32'(dmem_we), (run_now && op == OP_STA) ? 1 : 0);
         chk("dmem_re", 32'(dmem_re),
             (run_now && (op == OP_LDA || op == OP_ADD || op == OP_SUB)) ? 1 : 0);
         if (dmem_we === 1'b1) chk("dmem_wdata", 32'(dmem_wdata), 32'(m_acc));
`ifdef OVERFLOW_FLAG_EN
         chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
      cap_we = dmem_we; cap_addr = dmem_addr; cap_data = dmem_wdata;
      model_step(st, rs);
      @(posedge clk);
      #1;
      if (cap_we === 1'b1) dmem[cap_addr] = cap_data;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         imem[i] = {OP_HLT, 5'd0};
         dmem[i] = 8'h00;
         m_mem[i] = 8'h00;
      end
   endtask

   task automatic put(input int a, input logic [2:0] op, input logic [4:0] opr);
      imem[a[4:0]] = {op, opr};
   endtask

   task automatic setmem(input int a, input logic [7:0] v);
      dmem[a[4:0]] = v;
      m_mem[a[4:0]] = v;
   endtask

   task automatic run_to_halt(input int budget);
      int n;
      n = 0;
      cycle(1'b1, 1'b0, 1'b1);
      while (m_state == S_RUN && n < budget) begin
         cycle(1'b0, 1'b0, 1'b1);
         n++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
   endtask

   initial begin
      m_state = S_IDLE; m_pc = 0; m_acc = 8'h00; m_ovf = 1'b0;
      clear_mem();

      // Reset, then idle with start held low.
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);
      chk("idle_acc", 32'(acc), 32'd0);
      chk("idle_pc", 32'(imem_addr), 32'd0);
      chk("idle_running", 32'(running), 32'd0);
      chk("idle_we", 32'(dmem_we), 32'd0);
      $display("step idle: acc=%0h pc=%0d", acc, imem_addr);

      // LDA 3; ADD 4; STA 5; HLT
      clear_mem();
      put(0, OP_LDA, 5'd3); put(1, OP_ADD, 5'd4); put(2, OP_STA, 5'd5); put(3, OP_HLT, 5'd0);
      setmem(3, 8'h10); setmem(4, 8'h25);
      run_to_halt(20);
      chk("sta_mem5", 32'(dmem[5]), 32'h35);
      chk("hlt_pc", 32'(imem_addr), 32'd3);
      chk("hlt_acc", 32'(acc), 32'h35);
      $display("step add-store: mem[5]=%0h pc=%0d halted=%0b", dmem[5], imem_addr, halted);

      // LDI negative operand, then SUB 1.
      clear_mem();
      put(0, OP_LDI, 5'b11110); put(1, OP_SUB, 5'd10); put(2, OP_HLT, 5'd0);
      setmem(10, 8'h01);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("ldi_acc", 32'(acc), 32'hFE);
      cycle(1'b0, 1'b0, 1'b1);
      chk("sub_acc", 32'(acc), 32'hFD);
      cycle(1'b0, 1'b0, 1'b1);
      chk("ldi_halted", 32'(halted), 32'd1);
      $display("step ldi-sub: acc=%0h", acc);

      // JEZ taken/not taken, JMP 31 and PC wrap.
      clear_mem();
      put(0, OP_JEZ, 5'd7); put(1, OP_HLT, 5'd0); put(7, OP_LDI, 5'd1);
      put(8, OP_JEZ, 5'd7); put(9, OP_JMP, 5'd31); put(31, OP_LDI, 5'd2);
      cycle(1'b1, 1'b0, 1'b1);
      chk("start_pc", 32'(imem_addr), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("jez_taken", 32'(imem_addr), 32'd7);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("jez_not_taken", 32'(imem_addr), 32'd9);
      cycle(1'b0, 1'b0, 1'b1);
      chk("jmp31", 32'(imem_addr), 32'd31);
      cycle(1'b0, 1'b0, 1'b1);
      chk("pc_wrap", 32'(imem_addr), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("jez_acc2", 32'(imem_addr), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("jump_halted", 32'(halted), 32'd1);
      $display("step jumps: pc=%0d halted=%0b", imem_addr, halted);

      // Reset coinciding with STA.
      clear_mem();
      put(0, OP_LDI, 5'd3); put(1, OP_STA, 5'd9); put(2, OP_HLT, 5'd0);
      setmem(9, 8'hAA);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_pc", 32'(imem_addr), 32'd0);
      chk("rst_mem9", 32'(dmem[9]), 32'hAA);
      cycle(1'b0, 1'b0, 1'b1);
      $display("step reset-on-store: mem[9]=%0h running=%0b", dmem[9], running);

`ifdef OVERFLOW_FLAG_EN
      clear_mem();
      put(0, OP_LDA, 5'd1); put(1, OP_ADD, 5'd2); put(2, OP_LDI, 5'd0); put(3, OP_HLT, 5'd0);
      setmem(1, 8'h7F); setmem(2, 8'h01);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("ovf_acc", 32'(acc), 32'h80);
      chk("ovf_set", 32'(ovf), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(ovf), 32'd0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
      $display("step overflow: ovf=%0b", ovf);
`endif

      // Random programs with stray start pulses.
      for (int t = 0; t < 4; t++) begin
         logic [2:0] op;
         clear_mem();
         for (int i = 0; i < 32; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_HLT && $urandom_range(0, 3) != 0) op = OP_LDA;
            put(i, op, 5'($urandom));
            setmem(i, 8'($urandom));
         end
         cycle(1'b1, 1'b0, 1'b1);
         for (int c = 0; c < 60; c++) cycle(($urandom_range(0, 9) == 0), 1'b0, 1'b1);
         for (int i = 0; i < 32; i++) chk("rand_mem", 32'(dmem[i]), 32'(m_mem[i]));
         $display("step random %0d: acc=%0h pc=%0d halted=%0b", t, acc, imem_addr, halted);
         cycle(1'b0, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
